// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared MIPS16 memory defaults, dump FSM encoding and flat-image slicing
package mips16_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_e;

  // Word 0 sits in the MSBs of a flat image; returns the LSB offset of word idx.
  function automatic int word_lsb(input int data_w, input int depth, input int idx);
    return data_w * (depth - 1 - idx);
  endfunction

endpackage

// File: rtl/mem_dump_streamer.sv
// rtl/mem_dump_streamer.sv - valid/ready full-memory dump FSM, address counter and output register
module mem_dump_streamer
  import mips16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // cap_data is the word at cap_addr as it will be after this edge, so
  // same-cycle writes and reloads are already folded in by the storage.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    cap_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_DUMP;
          addr_d  = '0;
          data_d  = cap_data;
          valid_d = 1'b1;
        end
      end
      ST_DUMP: begin
        cap_addr = addr_q + ADDR_W'(1);
        if (valid_q && dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = cap_addr;
            data_d = cap_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;
  assign busy       = (state_q == ST_DUMP);

endmodule

// File: rtl/mips_data_mem_dump.sv
// rtl/mips_data_mem_dump.sv - MIPS16 data memory with preload, soft reload and streaming dump port
module mips_data_mem_dump
  import mips16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W*DEPTH-1:0] init_data,
  input  logic                    reload,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W-1:0]       mem_rdata,
  input  logic                    dump_req,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [ADDR_W-1:0]       dump_addr,
  output logic [DATA_W-1:0]       dump_data,
  output logic                    dump_done,
  output logic                    busy
);

  logic [DATA_W-1:0] mem_q     [DEPTH];
  logic [DATA_W-1:0] mem_d     [DEPTH];
  logic [DATA_W-1:0] init_word [DEPTH];
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_init
    assign init_word[g] = init_data[word_lsb(DATA_W, DEPTH, g) +: DATA_W];
  end

  // Reload takes priority over a CPU write in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (reload) begin
        mem_d[i] = init_word[i];
      end else if (mem_we && mem_addr == ADDR_W'(i)) begin
        mem_d[i] = mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word[i];
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range addresses never match an entry and read back as zero.
  always_comb begin
    mem_rdata = '0;
    cap_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_addr == ADDR_W'(i)) mem_rdata = mem_q[i];
      if (cap_addr == ADDR_W'(i)) cap_data  = mem_d[i];
    end
  end

  mem_dump_streamer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_streamer (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .cap_addr  (cap_addr),
    .cap_data  (cap_data),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done),
    .busy      (busy)
  );

endmodule

// File: tb/tb_mips_data_mem_dump.sv
// tb/tb_mips_data_mem_dump.sv - self-checking bench for mips_data_mem_dump against a behavioural model
module tb_mips_data_mem_dump;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DATA_W*DEPTH-1:0] init_data;
  logic                    reload;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    dump_req;
  logic                    dump_valid;
  logic                    dump_ready;
  logic [ADDR_W-1:0]       dump_addr;
  logic [DATA_W-1:0]       dump_data;
  logic                    dump_done;
  logic                    busy;

  mips_data_mem_dump #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_data (init_data),
    .reload    (reload),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dump_req  (dump_req),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory contents plus the dump transaction in progress.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  logic [DATA_W-1:0] m_init [DEPTH];
  bit                m_busy;
  bit                m_done;
  int                m_idx;
  logic [DATA_W-1:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_idle();
    reload     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = '0;
    dump_req   = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic pack_init();
    for (int i = 0; i < DEPTH; i++)
      init_data[DATA_W*(DEPTH-i)-1 -: DATA_W] = m_init[i];
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int a);
    return (a < DEPTH) ? m_mem[a] : '0;
  endfunction

  // Apply reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_mem  = m_init;
    m_busy = 0;
    m_done = 0;
    check_eq("rst_valid", dump_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", dump_done, 0);
    check_eq("rst_addr", dump_addr, 0);
    check_eq("rst_data", dump_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock: check the combinational read, take the edge, advance the model, check registers.
  task automatic cycle();
    logic [DATA_W-1:0] nm [DEPTH];
    #1;
    check_eq("rdata", mem_rdata, model_read(int'(mem_addr)));
    @(posedge clk);
    nm = m_mem;
    if (reload) nm = m_init;
    else if (mem_we && int'(mem_addr) < DEPTH) nm[mem_addr] = mem_wdata;
    m_done = 0;
    if (!m_busy) begin
      if (dump_req) begin
        m_busy = 1;
        m_idx  = 0;
        m_data = nm[0];
      end
    end else if (dump_ready) begin
      if (m_idx == DEPTH - 1) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_idx++;
        m_data = nm[m_idx];
      end
    end
    m_mem = nm;
    #1;
    check_eq("valid", dump_valid, m_busy);
    check_eq("busy", busy, m_busy);
    check_eq("done", dump_done, m_done);
    if (m_busy) begin
      check_eq("daddr", dump_addr, m_idx);
      check_eq("ddata", dump_data, m_data);
    end
  endtask

  task automatic drain_dump();
    dump_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH && m_busy; k++) cycle();
    check_eq("drain_timeout", m_busy, 0);
    dump_ready = 1'b0;
    cycle();
  endtask

  initial begin
    set_idle();
    m_init[0] = 16'h0000;
    m_init[1] = 16'h0023;
    m_init[2] = 16'h0009;
    m_init[3] = 16'h0031;
    for (int i = 4; i < DEPTH; i++) m_init[i] = 16'($urandom);
    pack_init();
    do_reset();

    mem_addr = 5'd3;
    #1;
    check_eq("preload3", mem_rdata, 16'h0031);
    cycle();

    mem_we = 1'b1; mem_addr = 5'd2; mem_wdata = 16'hBEEF;
    cycle();
    mem_we = 1'b0;
    #1;
    check_eq("wr_beef", mem_rdata, 16'hBEEF);
    mem_we = 1'b1; mem_addr = 5'd30; mem_wdata = 16'hDEAD;
    cycle();
    mem_we = 1'b0;
    #1;
    check_eq("oor_read", mem_rdata, 16'h0000);
    for (int a = 0; a < DEPTH; a++) begin
      mem_addr = ADDR_W'(a);
      cycle();
    end

    // Full dump with ready held high; a dump_req on the final beat must be ignored.
    dump_req = 1'b1; dump_ready = 1'b1;
    cycle();
    dump_req = 1'b0;
    for (int k = 0; k < 2 * DEPTH && m_busy; k++) begin
      dump_req = (m_idx == DEPTH - 1);
      cycle();
    end
    dump_req = 1'b0;
    check_eq("full_done_busy", busy, 0);
    cycle();

    // Backpressure at addr 1 while the CPU overwrites the snapshotted word.
    dump_req = 1'b1; dump_ready = 1'b0;
    cycle();
    dump_req = 1'b0; dump_ready = 1'b1;
    cycle();
    dump_ready = 1'b0; mem_we = 1'b1; mem_addr = 5'd1; mem_wdata = 16'h1234;
    repeat (5) cycle();
    check_eq("bp_addr", dump_addr, 1);
    check_eq("bp_snapshot", dump_data, 16'h0023);
    dump_ready = 1'b1; mem_addr = 5'd2; mem_wdata = 16'h5555;
    cycle();
    mem_we = 1'b0;
    check_eq("fwd_addr", dump_addr, 2);
    check_eq("fwd_data", dump_data, 16'h5555);
    drain_dump();

    reload = 1'b1; mem_we = 1'b1; mem_addr = 5'd0; mem_wdata = 16'hFFFF;
    cycle();
    reload = 1'b0; mem_we = 1'b0;
    #1;
    check_eq("reload_wins", mem_rdata, 16'h0000);
    cycle();

    // Abort a dump by reset at addr 10, then confirm a fresh dump restarts at 0.
    dump_req = 1'b1; dump_ready = 1'b1;
    cycle();
    dump_req = 1'b0;
    for (int k = 0; k < 2 * DEPTH && !(m_busy && m_idx == 10); k++) cycle();
    check_eq("abort_at10", dump_addr, 10);
    set_idle();
    do_reset();
    check_eq("abort_no_done", dump_done, 0);
    cycle();
    dump_req = 1'b1;
    cycle();
    dump_req = 1'b0;
    check_eq("restart_addr", dump_addr, 0);
    drain_dump();

    for (int k = 0; k < 600; k++) begin
      reload     = ($urandom_range(0, 31) == 0);
      mem_we     = $urandom_range(0, 1) == 1;
      mem_addr   = ADDR_W'($urandom_range(0, 31));
      mem_wdata  = 16'($urandom);
      dump_req   = ($urandom_range(0, 9) == 0);
      dump_ready = $urandom_range(0, 1) == 1;
      cycle();
    end
    set_idle();
    drain_dump();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_data_mem_dump.md
Name: mips_data_mem_dump

Overview:
Parametrised data memory for the MIPS16 core. It replaces the fixed 24x16 flat-bus data memory.
- Preloads from a flat init vector while reset is held.
- Serves single-cycle CPU reads and writes.
- Supports a soft reload from the init vector without reset.
- Adds a valid/ready dump port that streams every word out after a request, so benches and debug logic can read final memory state without hierarchical peeking.

Parameters:
DATA_W, 16, word width in bits
DEPTH, 24, number of words
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
init_data  in  DATA_W*DEPTH  flat preload image; word i at bits [DATA_W*(DEPTH-i)-1 -: DATA_W] (word 0 in MSBs)
reload  in  1  one-cycle pulse: copy init_data into memory at next edge
mem_addr  in  ADDR_W  CPU word address
mem_we  in  1  CPU write enable
mem_wdata  in  DATA_W  CPU write data
mem_rdata  out  DATA_W  CPU read data, combinational
dump_req  in  1  pulse: start a full-memory dump
dump_valid  out  1  dump word present
dump_ready  in  1  consumer accepts the dump word
dump_addr  out  ADDR_W  address of the presented word
dump_data  out  DATA_W  presented word
dump_done  out  1  one-cycle pulse after the last word is accepted
busy  out  1  high while in DUMP

Behaviour:
- Reset (rst=0, asynchronous):
  - Every word is loaded from init_data, continuously while rst is low.
  - FSM goes to IDLE.
  - dump_valid=0, dump_addr=0, dump_data=0, dump_done=0, busy=0.
- Reads:
  - mem_rdata = mem[mem_addr] combinationally; zero latency.
  - If mem_addr >= DEPTH, mem_rdata = 0.
- Writes:
  - On a rising edge with mem_we=1 and mem_addr < DEPTH, the word is updated.
  - Writes with mem_addr >= DEPTH are ignored.
  - A read of the same address in the same cycle returns the old value.
- Reload:
  - reload=1 at an edge overwrites all words from init_data.
  - reload wins over a simultaneous mem_we.
  - reload is allowed in any FSM state.
- FSM states: IDLE, DUMP.
- IDLE:
  - dump_req=1 -> DUMP.
  - On the same edge: dump_addr=0, dump_data is captured from word 0, dump_valid=1, busy=1.
- DUMP:
  - dump_addr, dump_data and dump_valid stay stable while dump_valid=1 and dump_ready=0.
  - On a handshake (valid and ready) with dump_addr < DEPTH-1: dump_addr increments and dump_data captures the next word.
  - On a handshake with dump_addr == DEPTH-1: dump_valid=0, dump_done=1 for exactly one cycle, busy=0, return to IDLE.
  - dump_req is ignored while in DUMP.
- Capture rule for dump_data:
  - The captured value is the memory word after that same edge's write.
  - If mem_we targets the captured address in that cycle, mem_wdata is forwarded.
  - If reload fires in that cycle, the corresponding init_data word is forwarded.
  - Once presented, a word is a snapshot; later writes to that address do not change it.
- dump_ready high in back-to-back cycles streams one word per cycle. A full dump of DEPTH words takes DEPTH handshake cycles.
- Reset mid-dump: asserting rst aborts immediately.
  - No dump_done is produced.
  - State returns to IDLE.
  - Memory is reloaded from init_data.
- dump_done and a new dump_req in the same cycle: dump_req is ignored, because the FSM is still in DUMP at that edge.

Decomposition:
- Shared package mips16_pkg holds:
  - default DATA_W and DEPTH;
  - the FSM state encoding (IDLE=0, DUMP=1);
  - the flat-vector slice function (word index to bit offset), shared with the instruction memory.
- One natural sub-module: mem_dump_streamer, containing the FSM, address counter and output register. It takes a read-port and forwarding interface from the storage array.

Test Plan:
- Preload: init_data words 0..3 = 0x0000, 0x0023, 0x0009, 0x0031. Hold rst=0, then release; drive mem_addr=3 -> mem_rdata=0x0031 with no clock edge needed.
- Write/read and out-of-range: mem_we=1, addr=2, wdata=0xBEEF -> next cycle mem_rdata=0xBEEF. Write to addr=30 -> no word changes; reading addr=30 returns 0.
- Full dump with ready always high: dump_req pulse -> DEPTH consecutive valid beats, dump_addr 0..23 with matching contents, then dump_done high for one cycle and busy=0.
- Backpressure and snapshot:
  - Hold dump_ready=0 for 5 cycles at addr=1 while writing 0x1234 to addr 1 -> dump_data stays 0x0023.
  - Write 0x5555 to addr 2 in the accept cycle -> the next beat shows 0x5555.
- Reload and reset:
  - reload together with mem_we to addr 0 -> word 0 equals the init value.
  - Drop rst mid-dump at addr=10 -> dump_valid=0 immediately, no dump_done, and a later dump restarts at addr 0.
